// File: rtl/mc_mainfsm.sv
// Multicycle RISC-V main control FSM: sequences fetch/decode/execute/writeback and drives datapath selects.
// Latency: 3-5 cycles per instruction plus one per mem_ready=0 cycle; outputs are combinational from current state.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold until mem_ready; all other states advance every cycle.
module mc_mainfsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_src,
  output logic       illegal_op,
  output logic       instr_retired,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_t cur;

  assign state = cur;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= S_FETCH;
    end else begin
      case (cur)
        S_FETCH:    if (mem_ready) cur <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: cur <= S_MEMADR;
            OP_R:              cur <= S_EXECUTER;
            OP_IMM:            cur <= S_EXECUTEI;
            OP_BRANCH:         cur <= S_BRANCH;
            OP_JAL:            cur <= S_JAL;
            OP_JALR:           cur <= S_JALR;
            OP_LUI:            cur <= S_LUI;
            OP_AUIPC:          cur <= S_AUIPC;
            default:           cur <= S_FETCH;
          endcase
        end
        S_MEMADR:   cur <= (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (mem_ready) cur <= S_MEMWB;
        S_MEMWRITE: if (mem_ready) cur <= S_FETCH;
        S_EXECUTER, S_EXECUTEI, S_LUI, S_AUIPC: cur <= S_ALUWB;
        S_JALR:     cur <= S_JAL;
        S_JAL:      cur <= S_ALUWB;
        default:    cur <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    illegal_op    = 1'b0;
    instr_retired = 1'b0;

    case (op)
      OP_STORE:        imm_src = 3'b001;
      OP_BRANCH:       imm_src = 3'b010;
      OP_JAL:          imm_src = 3'b011;
      OP_LUI, OP_AUIPC: imm_src = 3'b100;
      default:         imm_src = 3'b000;
    endcase

    case (cur)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        // Precompute old_pc+imm into alu_out for branch/jump targets.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LOAD, OP_STORE, OP_R, OP_IMM, OP_BRANCH,
          OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: illegal_op = 1'b0;
          default:                           illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write     = 1'b1;
        instr_retired = mem_ready;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 2'b10;
        alu_op        = 2'b01;
        pc_write      = branch_taken;
        instr_retired = 1'b1;
      end
      S_JAL: begin
        // ALU forms old_pc+4 for the link write in ALUWB; PC loads the DECODE target.
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      S_JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
      end
      S_AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      default: ;
    endcase

    if (reset) begin
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      illegal_op    = 1'b0;
      instr_retired = 1'b0;
    end
  end

endmodule
